// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The FETCH_PERF_CNT_EN macro controls the optional performance counters in the top module.
package instruction_fetch_unit_pkg;

    localparam int unsigned FETCH_QUEUE_DEPTH = 2;
    localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_WAIT,
        FETCH_DROP
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory port of the fetch stage.
// Handshake: a request is accepted on a rising clock edge where instr_req_op and instr_gnt_ip are
// both high. instr_addr_op must stay stable while the request waits for its grant. Exactly one
// instr_rvalid_ip cycle answers each accepted request, on a later cycle.
interface instruction_fetch_unit_if;
    import instruction_fetch_unit_pkg::*;

    logic        instr_req_op;
    logic [31:0] instr_addr_op;
    logic        instr_gnt_ip;
    logic        instr_rvalid_ip;
    logic [31:0] instr_rdata_ip;

    modport master (
        output instr_req_op,
        output instr_addr_op,
        input  instr_gnt_ip,
        input  instr_rvalid_ip,
        input  instr_rdata_ip
    );

    modport slave (
        input  instr_req_op,
        input  instr_addr_op,
        output instr_gnt_ip,
        output instr_rvalid_ip,
        output instr_rdata_ip
    );
endinterface

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Two-entry prefetch FIFO of {pc, instr}. Entry 0 is always the head.
// Clear has priority over push and pop.
module fetch_queue
    import instruction_fetch_unit_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t push_entry,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t entry0_q;
    fetch_entry_t entry1_q;
    logic [1:0]   count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= 2'd0;
        end else if (clear) begin
            count_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        entry0_q <= push_entry;
                        count_q  <= 2'd1;
                    end else if (count_q == 2'd1) begin
                        entry1_q <= push_entry;
                        count_q  <= 2'd2;
                    end
                end
                2'b01: begin
                    if (count_q != 2'd0) begin
                        entry0_q <= entry1_q;
                        count_q  <= count_q - 2'd1;
                    end
                end
                2'b11: begin
                    // Simultaneous push and pop: count holds, order is kept.
                    if (count_q == 2'd1) begin
                        entry0_q <= push_entry;
                    end else if (count_q == 2'd2) begin
                        entry0_q <= entry1_q;
                        entry1_q <= push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head  = entry0_q;
    assign count = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: one outstanding word request, 2-entry prefetch queue, stall and flush handling.
// Define FETCH_PERF_CNT_EN to add the fetch_count_op / flush_count_op counters.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR   = BOOT_ADDR_DEFAULT,
    parameter int unsigned QUEUE_DEPTH = FETCH_QUEUE_DEPTH
) (
    input  logic                      clock,
    input  logic                      reset,
    output logic [31:0]               pc_op,
    output logic [31:0]               pc4_op,
    output logic                      instr_data_valid_op,
    output logic [31:0]               instr_data_op,
    input  logic                      stall_ip,
    input  logic                      flush_en_ip,
    input  logic [31:0]               branch_target_ip,
    instruction_fetch_unit_if.master  mem_if,
    output fetch_state_e              fetch_state_op
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]               fetch_count_op,
    output logic [31:0]               flush_count_op
`endif
);

    localparam logic [1:0] FULL_COUNT = 2'(QUEUE_DEPTH);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic [31:0]  addr_q, addr_d;
    logic         redirect_q, redirect_d;
    logic         start_req;

    logic         push, pop;
    logic [1:0]   count, count_next;
    fetch_entry_t head;

    fetch_queue u_queue (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .clear      (flush_en_ip),
        .push_entry ({req_pc_q, mem_if.instr_rdata_ip}),
        .head       (head),
        .count      (count)
    );

    assign instr_data_valid_op = (count != 2'd0) && !flush_en_ip;
    assign pop  = instr_data_valid_op && !stall_ip;
    assign push = (state_q == FETCH_WAIT) && mem_if.instr_rvalid_ip && !flush_en_ip;

    always_comb begin
        count_next = count;
        if (flush_en_ip) begin
            count_next = 2'd0;
        end else begin
            count_next = count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        addr_d     = addr_q;
        redirect_d = redirect_q;
        start_req  = 1'b0;

        case (state_q)
            FETCH_IDLE: begin
                if (count_next < FULL_COUNT) start_req = 1'b1;
            end
            FETCH_REQ: begin
                if (mem_if.instr_gnt_ip) begin
                    req_pc_d   = addr_q;
                    redirect_d = 1'b0;
                    // A grant after a redirect fetches a stale word: let it land and discard it.
                    if (redirect_q || flush_en_ip) begin
                        state_d = FETCH_DROP;
                    end else begin
                        state_d    = FETCH_WAIT;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end else if (flush_en_ip) begin
                    redirect_d = 1'b1;
                end
            end
            FETCH_WAIT: begin
                if (mem_if.instr_rvalid_ip) begin
                    if (count_next < FULL_COUNT) start_req = 1'b1;
                    else                         state_d   = FETCH_IDLE;
                end else if (flush_en_ip) begin
                    state_d = FETCH_DROP;
                end
            end
            FETCH_DROP: begin
                if (mem_if.instr_rvalid_ip) start_req = 1'b1;
            end
            default: state_d = FETCH_IDLE;
        endcase

        if (flush_en_ip) fetch_pc_d = branch_target_ip;

        // A request launched in a flush cycle must already target the redirect address.
        if (start_req) begin
            state_d = FETCH_REQ;
            addr_d  = flush_en_ip ? branch_target_ip : fetch_pc_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= FETCH_IDLE;
            fetch_pc_q <= BOOT_ADDR;
            req_pc_q   <= 32'h0;
            addr_q     <= 32'h0;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            addr_q     <= addr_d;
            redirect_q <= redirect_d;
        end
    end

    assign mem_if.instr_req_op  = (state_q == FETCH_REQ);
    assign mem_if.instr_addr_op = addr_q;

    assign pc_op          = head.pc;
    assign pc4_op         = head.pc + 32'd4;
    assign instr_data_op  = head.instr;
    assign fetch_state_op = state_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q, flush_count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_count_q <= 32'h0;
            flush_count_q <= 32'h0;
        end else begin
            if (pop)         fetch_count_q <= fetch_count_q + 32'd1;
            if (flush_en_ip) flush_count_q <= flush_count_q + 32'd1;
        end
    end

    assign fetch_count_op = fetch_count_q;
    assign flush_count_op = flush_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table, corner-case sequences and a
// randomized run against an in-order delivered-stream model with a memory responder.
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         stall = 1'b0;
    logic         flush = 1'b0;
    logic [31:0]  target = 32'h0;
    logic [31:0]  pc, pc4, instr;
    logic         valid;
    fetch_state_e fstate;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]  fetch_count, flush_count;
`endif

    always #5 clock = ~clock;

    instruction_fetch_unit_if mem_if ();

    instruction_fetch_unit dut (
        .clock               (clock),
        .reset               (reset),
        .pc_op               (pc),
        .pc4_op              (pc4),
        .instr_data_valid_op (valid),
        .instr_data_op       (instr),
        .stall_ip            (stall),
        .flush_en_ip         (flush),
        .branch_target_ip    (target),
        .mem_if              (mem_if),
        .fetch_state_op      (fstate)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count_op      (fetch_count),
        .flush_count_op      (flush_count)
`endif
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Memory responder state: addresses accepted and not yet answered.
    logic [31:0] exp_q[$];
    bit          const_mem = 1'b1;
    int          gnt_cfg = 0;
    int          rv_cfg = 0;
    bit          rv_drv, acc, in_req;
    logic [31:0] acc_addr;
    int          gnt_cnt, rv_cnt;

    typedef struct {
        int          cyc;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return const_mem ? 32'h0000_0013 : {a[15:0], ~a[31:16]};
    endfunction

    function automatic int pick(input int cfg);
        return (cfg < 0) ? int'($urandom_range(0, 2)) : cfg;
    endfunction

    task automatic mem_drive();
        if (rv_drv) void'(exp_q.pop_front());
        if (acc) begin
            exp_q.push_back(acc_addr);
            rv_cnt = pick(rv_cfg);
        end
        rv_drv = (exp_q.size() != 0) && (rv_cnt == 0);
        if ((exp_q.size() != 0) && (rv_cnt != 0)) rv_cnt--;
        mem_if.instr_rvalid_ip = rv_drv;
        mem_if.instr_rdata_ip  = rv_drv ? mem_fn(exp_q[0]) : $urandom;
        if (mem_if.instr_req_op && !in_req) begin
            in_req  = 1'b1;
            gnt_cnt = pick(gnt_cfg);
        end
        mem_if.instr_gnt_ip = mem_if.instr_req_op && (gnt_cnt == 0);
        if (mem_if.instr_req_op && (gnt_cnt != 0)) gnt_cnt--;
        acc      = mem_if.instr_req_op && mem_if.instr_gnt_ip;
        acc_addr = mem_if.instr_addr_op;
        if (acc) in_req = 1'b0;
    endtask

    task automatic tick();
        @(negedge clock);
        cyc++;
        mem_drive();
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; flush = 1'b0; target = 32'h0;
        mem_if.instr_gnt_ip = 1'b0; mem_if.instr_rvalid_ip = 1'b0; mem_if.instr_rdata_ip = 32'h0;
        exp_q.delete();
        rv_drv = 1'b0; acc = 1'b0; in_req = 1'b0; gnt_cnt = 0; rv_cnt = 0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic expect_req(input string name, input logic [31:0] addr);
        int n = 0;
        while (!mem_if.instr_req_op && n < 40) begin tick(); #1; n++; end
        if (!mem_if.instr_req_op) chk({name, "_timeout"}, 32'd0, 32'd1);
        else                      chk(name, mem_if.instr_addr_op, addr);
    endtask

    task automatic expect_pop(input string name, input logic [31:0] exp_pc);
        int n = 0;
        stall = 1'b0;
        flush = 1'b0;
        #1;
        while (!valid && n < 40) begin tick(); #1; n++; end
        if (!valid) begin
            chk({name, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({name, "_pc"}, pc, exp_pc);
            chk({name, "_pc4"}, pc4, exp_pc + 32'd4);
            chk({name, "_instr"}, instr, mem_fn(exp_pc));
        end
        tick(); #1;
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] prev_addr;
        bit          prev_hold;
        int          pops, flushes;

        // Zero-wait memory: request timing and delivery every 2 cycles.
        tbl[0] = '{1, 1'b1, 32'h0,  1'b0, 32'h0};
        tbl[1] = '{2, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[2] = '{3, 1'b1, 32'h4,  1'b1, 32'h0};
        tbl[3] = '{4, 1'b0, 32'h4,  1'b0, 32'h0};
        tbl[4] = '{5, 1'b1, 32'h8,  1'b1, 32'h4};
        tbl[5] = '{6, 1'b0, 32'h8,  1'b0, 32'h0};
        tbl[6] = '{7, 1'b1, 32'hC,  1'b1, 32'h8};

        const_mem = 1'b1; gnt_cfg = 0; rv_cfg = 0;
        do_reset();
        #1;
        chk("reset_pc", pc, 32'h0);
        chk("reset_pc4", pc4, 32'h4);
        chk("reset_instr", instr, 32'h0);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_req", 32'(mem_if.instr_req_op), 32'd0);
        chk("reset_addr", mem_if.instr_addr_op, 32'h0);
        chk("reset_state", 32'(fstate), 32'(FETCH_IDLE));
        for (int i = 0; i < 7; i++) begin
            while (cyc < tbl[i].cyc) begin tick(); #1; end
            chk("tbl_req", 32'(mem_if.instr_req_op), 32'(tbl[i].req));
            chk("tbl_addr", mem_if.instr_addr_op, tbl[i].addr);
            chk("tbl_valid", 32'(valid), 32'(tbl[i].valid));
            if (tbl[i].valid) begin
                chk("tbl_pc", pc, tbl[i].pc);
                chk("tbl_instr", instr, 32'h0000_0013);
            end
        end

        // Stall: queue fills, requests stop, head holds pc 0.
        do_reset();
        stall = 1'b1;
        while (cyc < 5) tick();
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("stall_req_off", 32'(mem_if.instr_req_op), 32'd0);
            chk("stall_valid", 32'(valid), 32'd1);
            chk("stall_head_pc", pc, 32'h0);
            tick();
        end
        expect_pop("stall_pop0", 32'h0);
        expect_pop("stall_pop1", 32'h4);
        expect_pop("stall_pop2", 32'h8);

        // Flush while waiting for the response.
        const_mem = 1'b0; gnt_cfg = 0; rv_cfg = 2;
        do_reset();
        while (cyc < 2) tick();
        chk("wait_state", 32'(fstate), 32'(FETCH_WAIT));
        flush = 1'b1; target = 32'h100;
        #1;
        chk("wait_flush_valid", 32'(valid), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("wait_drop_state", 32'(fstate), 32'(FETCH_DROP));
        expect_req("wait_redirect_addr", 32'h100);
        expect_pop("wait_first_pop", 32'h100);
        expect_pop("wait_second_pop", 32'h104);

        // Flush while the request waits 3 cycles for its grant.
        gnt_cfg = 3; rv_cfg = 0;
        do_reset();
        while (cyc < 2) tick();
        flush = 1'b1; target = 32'h100;
        #1;
        chk("req_flush_req", 32'(mem_if.instr_req_op), 32'd1);
        chk("req_flush_addr", mem_if.instr_addr_op, 32'h0);
        tick();
        flush = 1'b0;
        #1;
        chk("req_hold_addr3", mem_if.instr_addr_op, 32'h0);
        chk("req_hold_req3", 32'(mem_if.instr_req_op), 32'd1);
        tick(); #1;
        chk("req_hold_addr4", mem_if.instr_addr_op, 32'h0);
        chk("req_gnt4", 32'(mem_if.instr_gnt_ip), 32'd1);
        gnt_cfg = 0;
        tick(); #1;
        chk("req_drop_state", 32'(fstate), 32'(FETCH_DROP));
        expect_req("req_redirect_addr", 32'h100);
        expect_pop("req_first_pop", 32'h100);

        // rvalid and flush in the same cycle under stall, then pc wrap.
        gnt_cfg = 0; rv_cfg = 0;
        do_reset();
        stall = 1'b1;
        while (cyc < 4) tick();
        chk("same_rvalid", 32'(mem_if.instr_rvalid_ip), 32'd1);
        chk("same_state", 32'(fstate), 32'(FETCH_WAIT));
        flush = 1'b1; target = 32'h200;
        #1;
        chk("same_flush_valid", 32'(valid), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("same_next_valid", 32'(valid), 32'd0);
        chk("same_next_state", 32'(fstate), 32'(FETCH_REQ));
        chk("same_next_addr", mem_if.instr_addr_op, 32'h200);
        expect_pop("same_pop", 32'h200);
        flush = 1'b1; target = 32'hFFFF_FFF8;
        tick();
        flush = 1'b0;
        expect_pop("wrap_pop0", 32'hFFFF_FFF8);
        expect_pop("wrap_pop1", 32'hFFFF_FFFC);
        expect_pop("wrap_pop2", 32'h0);

        // Randomized run: the delivered stream must be consecutive words from the last redirect.
        gnt_cfg = -1; rv_cfg = -1;
        do_reset();
        exp_pc = BOOT_ADDR_DEFAULT; pops = 0; flushes = 0; prev_hold = 1'b0; prev_addr = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 24) == 0);
            case ($urandom_range(0, 3))
                0:       target = 32'hFFFF_FFF8;
                1:       target = 32'h100;
                default: target = $urandom & 32'hFFFF_FFFC;
            endcase
            #1;
            if (prev_hold) begin
                chk("rnd_req_held", 32'(mem_if.instr_req_op), 32'd1);
                chk("rnd_addr_held", mem_if.instr_addr_op, prev_addr);
            end
            prev_hold = mem_if.instr_req_op && !mem_if.instr_gnt_ip;
            prev_addr = mem_if.instr_addr_op;
            if (mem_if.instr_req_op) chk("rnd_one_outstanding", exp_q.size(), 32'd0);
            if (flush) begin
                chk("rnd_flush_valid", 32'(valid), 32'd0);
                exp_pc = target;
                flushes++;
            end else if (valid && !stall) begin
                chk("rnd_pc", pc, exp_pc);
                chk("rnd_pc4", pc4, exp_pc + 32'd4);
                chk("rnd_instr", instr, mem_fn(exp_pc));
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
        end
        chk("rnd_progress", 32'(pops >= 100), 32'd1);
        @(posedge clock);
        #1;
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch_count", fetch_count, pops);
        chk("perf_flush_count", flush_count, flushes);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
